// File: rtl/lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pkg: access-size encodings, FSM states and lane helpers       |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_load_align: extract the addressed lane(s) of a RAM word and   |
// | zero/sign-extend to 32 bits.  Rev 1.0                             |
// +------------------------------------------------------------------+
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] result
);

   logic [31:0] w_shifted;

   // Half accesses are aligned, so a byte-granular shift serves both sizes.
   assign w_shifted = word >> {off, 3'b000};

   always_comb begin
      case (size)
         SZ_BYTE: result = {{24{sign_ext & w_shifted[7]}}, w_shifted[7:0]};
         SZ_HALF: result = {{16{sign_ext & w_shifted[15]}}, w_shifted[15:0]};
         default: result = word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_bram_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_bram_master: single-outstanding load/store initiator for a    |
// | single-port block RAM. Optional counters: LSU_ACCESS_CNT_EN.      |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module lsu_bram_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
`ifdef LSU_ACCESS_CNT_EN
   ,
   output logic [31:0]       load_cnt,
   output logic [31:0]       store_cnt,
   output logic [15:0]       err_cnt
`endif
);

   localparam logic [1:0] C_WAIT_LAST = 2'(READ_LAT - 1);

   state_t              state_q, state_d;
   logic                req_ready_q, req_ready_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic [31:0]         resp_rdata_q, resp_rdata_d;
   logic                mem_en_q, mem_en_d;
   logic [3:0]          mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_din_q, mem_din_d;
   logic                we_q, we_d;
   logic                signed_q, signed_d;
   logic [1:0]          size_q, size_d;
   logic [1:0]          off_q, off_d;
   logic [1:0]          wait_cnt_q, wait_cnt_d;

   logic                w_accept;
   logic                w_req_err;
   logic [31:0]         w_store_data;
   logic [31:0]         w_load_data;

   assign w_accept  = req_valid && req_ready_q;
   assign w_req_err = (req_size == 2'd3) || misaligned(req_size, req_addr[1:0])
                    || (|(req_addr >> (ADDR_W + 2)));

   always_comb begin
      case (req_size)
         SZ_BYTE: w_store_data = {4{req_wdata[7:0]}};
         SZ_HALF: w_store_data = {2{req_wdata[15:0]}};
         default: w_store_data = req_wdata;
      endcase
   end

   lsu_load_align u_align (
      .word     (mem_dout),
      .off      (off_q),
      .size     (size_q),
      .sign_ext (signed_q),
      .result   (w_load_data)
   );

   // All outputs are computed one cycle ahead so they leave the block registered.
   always_comb begin
      state_d      = state_q;
      req_ready_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      mem_en_d     = 1'b0;
      mem_we_d     = '0;
      mem_addr_d   = '0;
      mem_din_d    = '0;
      we_d         = we_q;
      signed_d     = signed_q;
      size_d       = size_q;
      off_d        = off_q;
      wait_cnt_d   = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (w_accept) begin
               req_ready_d = 1'b0;
               we_d        = req_we;
               signed_d    = req_signed;
               size_d      = req_size;
               off_d       = req_addr[1:0];
               if (w_req_err) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d    = ST_ISSUE;
                  mem_en_d   = 1'b1;
                  mem_addr_d = req_addr[ADDR_W+1:2];
                  if (req_we) begin
                     mem_we_d  = lane_mask(req_size, req_addr[1:0]);
                     mem_din_d = w_store_data;
                  end
               end
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
            end else begin
               state_d    = ST_WAIT;
               wait_cnt_d = C_WAIT_LAST;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == 2'd0) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = w_load_data;
            end else begin
               wait_cnt_d = wait_cnt_q - 2'd1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= '0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         we_q         <= 1'b0;
         signed_q     <= 1'b0;
         size_q       <= SZ_BYTE;
         off_q        <= 2'b00;
         wait_cnt_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         we_q         <= we_d;
         signed_q     <= signed_d;
         size_q       <= size_d;
         off_q        <= off_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;

`ifdef LSU_ACCESS_CNT_EN
   logic [31:0] load_cnt_q, load_cnt_d;
   logic [31:0] store_cnt_q, store_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      load_cnt_d  = load_cnt_q;
      store_cnt_d = store_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (state_q == ST_RESP) begin
         if (resp_err_q)  err_cnt_d   = err_cnt_q + 16'd1;
         else if (we_q)   store_cnt_d = store_cnt_q + 32'd1;
         else             load_cnt_d  = load_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         load_cnt_q  <= load_cnt_d;
         store_cnt_q <= store_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign load_cnt  = load_cnt_q;
   assign store_cnt = store_cnt_q;
   assign err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_bram_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lsu_bram_master: two DUTs (READ_LAT 1 and 3) against a byte-   |
// | level memory model. Rev 1.0                                        |
// +------------------------------------------------------------------+
module tb_lsu_bram_master;

   typedef struct {
      int          resp_cyc;
      int          en_cyc;
      bit          err;
      logic [3:0]  we;
      logic [9:0]  addr;
      logic [31:0] din;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we [2];
   logic [1:0]  req_size [2];
   logic        req_signed [2];
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic        resp_valid [2];
   logic        resp_err [2];
   logic [31:0] resp_rdata [2];
   logic        mem_en [2];
   logic [3:0]  mem_we [2];
   logic [9:0]  mem_addr [2];
   logic [31:0] mem_din [2];
   logic [31:0] mem_dout [2];
`ifdef LSU_ACCESS_CNT_EN
   logic [31:0] load_cnt [2];
   logic [31:0] store_cnt [2];
   logic [15:0] err_cnt [2];
`endif

   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;
   logic [7:0]  shadow [2][4096];
   exp_t        pend [2];
   bit          pend_v [2];
   int          acc_t [2];
   int          last_lat [2];
   logic        last_err [2];
   logic [31:0] last_rdata [2];
   logic [3:0]  obs_we [2];
   logic [9:0]  obs_addr [2];
   logic [31:0] obs_din [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [31:0] ram [1024];
      logic [31:0] pipe [LAT];

      initial begin
         for (int k = 0; k < 1024; k++) ram[k] = '0;
         for (int s = 0; s < LAT; s++) pipe[s] = '0;
      end

      always @(posedge clk) begin
         if (mem_en[gi]) begin
            for (int k = 0; k < 4; k++)
               if (mem_we[gi][k]) ram[mem_addr[gi]][8*k +: 8] <= mem_din[gi][8*k +: 8];
            pipe[0] <= ram[mem_addr[gi]];
         end
         for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
      end
      assign mem_dout[gi] = pipe[LAT-1];

      lsu_bram_master #(.ADDR_W(10), .READ_LAT(LAT)) u_dut (
         .clk        (clk),
         .rst        (rst[gi]),
         .req_valid  (req_valid[gi]),
         .req_ready  (req_ready[gi]),
         .req_we     (req_we[gi]),
         .req_size   (req_size[gi]),
         .req_signed (req_signed[gi]),
         .req_addr   (req_addr[gi]),
         .req_wdata  (req_wdata[gi]),
         .resp_valid (resp_valid[gi]),
         .resp_err   (resp_err[gi]),
         .resp_rdata (resp_rdata[gi]),
         .mem_en     (mem_en[gi]),
         .mem_we     (mem_we[gi]),
         .mem_addr   (mem_addr[gi]),
         .mem_din    (mem_din[gi]),
         .mem_dout   (mem_dout[gi])
`ifdef LSU_ACCESS_CNT_EN
         ,
         .load_cnt   (load_cnt[gi]),
         .store_cnt  (store_cnt[gi]),
         .err_cnt    (err_cnt[gi])
`endif
      );
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, i, act, exp, cyc);
   endtask

   // Model of one accepted request, working on byte addresses.
   task automatic model_accept(input int i, input int e);
      int          n;
      int          a;
      bit [31:0]   w;
      bit [31:0]   v;
      bit          err;
      a = int'(req_addr[i] & 32'h0000_0FFF);
      w = req_wdata[i];
      n = (req_size[i] == 2'd0) ? 1 : (req_size[i] == 2'd1) ? 2 : 4;
      err = (req_size[i] == 2'd3) || ((a % n) != 0) || (req_addr[i] >= 32'd4096);
      acc_t[i]         = e - 1;
      pend[i].err      = err;
      pend[i].en_cyc   = e;
      pend[i].we       = '0;
      pend[i].addr     = 10'(a / 4);
      pend[i].din      = '0;
      pend[i].rdata    = '0;
      if (err)             pend[i].resp_cyc = e;
      else if (req_we[i])  pend[i].resp_cyc = e + 1;
      else                 pend[i].resp_cyc = e + 1 + ((i == 0) ? 1 : 3);
      if (!err) begin
         if (req_we[i]) begin
            for (int j = 0; j < n; j++) begin
               pend[i].we[(a + j) % 4] = 1'b1;
               shadow[i][a + j] = w[8*j +: 8];
            end
            for (int k = 0; k < 4; k++) pend[i].din[8*k +: 8] = w[8*(k % n) +: 8];
         end else begin
            v = '0;
            for (int j = 0; j < n; j++) v = v | (32'(shadow[i][a + j]) << (8*j));
            if (req_signed[i] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            pend[i].rdata = v;
         end
      end
      pend_v[i] = 1'b1;
   endtask

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++)
         if (rst[i] && req_valid[i] && req_ready[i]) model_accept(i, cyc);
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            bit exp_en, exp_rv;
            exp_en = pend_v[i] && !pend[i].err && (cyc == pend[i].en_cyc);
            exp_rv = pend_v[i] && (cyc == pend[i].resp_cyc);
            chk("req_ready", i, 32'(req_ready[i]), 32'(!pend_v[i]));
            chk("mem_en", i, 32'(mem_en[i]), 32'(exp_en));
            chk("mem_we", i, 32'(mem_we[i]), exp_en ? 32'(pend[i].we) : 32'd0);
            if (mem_en[i]) begin
               obs_we[i]   = mem_we[i];
               obs_addr[i] = mem_addr[i];
               obs_din[i]  = mem_din[i];
            end
            if (exp_en) begin
               chk("mem_addr", i, 32'(mem_addr[i]), 32'(pend[i].addr));
               chk("mem_din", i, mem_din[i], pend[i].din);
            end
            chk("resp_valid", i, 32'(resp_valid[i]), 32'(exp_rv));
            if (resp_valid[i]) begin
               last_lat[i]   = cyc - acc_t[i];
               last_err[i]   = resp_err[i];
               last_rdata[i] = resp_rdata[i];
            end
            if (exp_rv) begin
               chk("resp_err", i, 32'(resp_err[i]), 32'(pend[i].err));
               chk("resp_rdata", i, resp_rdata[i], pend[i].rdata);
               pend_v[i] = 1'b0;
            end
         end
      end
   end

   task automatic issue(input int i, input bit we, input bit [1:0] sz, input bit sg,
                        input bit [31:0] a, input bit [31:0] w, input bit keep);
      int n = 0;
      @(negedge clk);
      req_valid[i] = 1'b1; req_we[i] = we; req_size[i] = sz;
      req_signed[i] = sg; req_addr[i] = a; req_wdata[i] = w;
      while (!req_ready[i] && n < 50) begin @(negedge clk); n++; end
      chk("accept_in_budget", i, 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      if (!keep) req_valid[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int n = 0;
      while (pend_v[i] && n < 100) begin @(negedge clk); n++; end
      chk("resp_in_budget", i, 32'(!pend_v[i]), 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input string nm, input int i);
      chk({nm, "_ready"}, i, 32'(req_ready[i]), 32'd1);
      chk({nm, "_rvalid"}, i, 32'(resp_valid[i]), 32'd0);
      chk({nm, "_rerr"}, i, 32'(resp_err[i]), 32'd0);
      chk({nm, "_rdata"}, i, resp_rdata[i], 32'd0);
      chk({nm, "_en"}, i, 32'(mem_en[i]), 32'd0);
      chk({nm, "_we"}, i, 32'(mem_we[i]), 32'd0);
      chk({nm, "_addr"}, i, 32'(mem_addr[i]), 32'd0);
      chk({nm, "_din"}, i, mem_din[i], 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0;
         req_signed[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; pend_v[i] = 1'b0;
         for (int k = 0; k < 4096; k++) shadow[i][k] = 8'h00;
      end
      repeat (2) @(posedge clk);
      #2;
      chk_idle_outputs("reset", 0);
      chk_idle_outputs("reset", 1);
      @(posedge clk); #1;
      rst[0] = 1'b1; rst[1] = 1'b1;

      // Word store/load, READ_LAT=1
      issue(0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0); wait_done(0);
      chk("st_w_we", 0, 32'(obs_we[0]), 32'hF);
      chk("st_w_addr", 0, 32'(obs_addr[0]), 32'd4);
      chk("st_w_din", 0, obs_din[0], 32'hDEAD_BEEF);
      chk("st_w_lat", 0, last_lat[0], 2);
      issue(0, 0, 2'd2, 0, 32'h10, 32'h0, 0); wait_done(0);
      chk("ld_w_data", 0, last_rdata[0], 32'hDEAD_BEEF);
      chk("ld_w_lat", 0, last_lat[0], 3);

      // Byte lane 3
      issue(0, 1, 2'd0, 0, 32'h13, 32'h0000_00A5, 0); wait_done(0);
      chk("st_b_we", 0, 32'(obs_we[0]), 32'h8);
      chk("st_b_din", 0, obs_din[0], 32'hA5A5_A5A5);
      issue(0, 0, 2'd0, 1, 32'h13, 32'h0, 0); wait_done(0);
      chk("ld_bs", 0, last_rdata[0], 32'hFFFF_FFA5);
      issue(0, 0, 2'd0, 0, 32'h13, 32'h0, 0); wait_done(0);
      chk("ld_bu", 0, last_rdata[0], 32'h0000_00A5);

      // Upper halfword
      issue(0, 1, 2'd1, 0, 32'h22, 32'h0000_8001, 0); wait_done(0);
      chk("st_h_we", 0, 32'(obs_we[0]), 32'hC);
      chk("st_h_din", 0, obs_din[0], 32'h8001_8001);
      issue(0, 0, 2'd1, 1, 32'h22, 32'h0, 0); wait_done(0);
      chk("ld_hs", 0, last_rdata[0], 32'hFFFF_8001);
      issue(0, 0, 2'd1, 0, 32'h22, 32'h0, 0); wait_done(0);
      chk("ld_hu", 0, last_rdata[0], 32'h0000_8001);

      // Rejected accesses
      issue(0, 0, 2'd2, 0, 32'h06, 32'h0, 0); wait_done(0);
      chk("err_w_mis", 0, {last_err[0], 31'(last_lat[0])}, {1'b1, 31'd1});
      issue(0, 1, 2'd1, 0, 32'h03, 32'hFFFF, 0); wait_done(0);
      chk("err_h_mis", 0, {last_err[0], 31'(last_lat[0])}, {1'b1, 31'd1});
      issue(0, 0, 2'd3, 0, 32'h00, 32'h0, 0); wait_done(0);
      chk("err_sz3", 0, {last_err[0], 31'(last_lat[0])}, {1'b1, 31'd1});
      issue(0, 0, 2'd2, 0, 32'h0000_1000, 32'h0, 0); wait_done(0);
      chk("err_range", 0, {last_err[0], 31'(last_lat[0])}, {1'b1, 31'd1});
      chk("err_rdata", 0, last_rdata[0], 32'd0);

      // Reset during WAIT, READ_LAT=3
      issue(1, 0, 2'd2, 0, 32'h0, 32'h0, 0);
      @(negedge clk); @(negedge clk); #2;
      rst[1] = 1'b0; pend_v[1] = 1'b0;
      #1;
      chk_idle_outputs("midrst", 1);
      @(posedge clk); #1;
      rst[1] = 1'b1;
      repeat (6) @(negedge clk);

      // Back-to-back with req_valid held, READ_LAT=3
      issue(1, 0, 2'd2, 0, 32'h40, 32'h0, 1);
      issue(1, 1, 2'd2, 0, 32'h40, 32'h1234_5678, 1);
      issue(1, 0, 2'd1, 1, 32'h42, 32'h0, 0);
      wait_done(1);
      chk("b2b_last", 1, last_rdata[1], 32'h0000_1234);
      chk("b2b_lat", 1, last_lat[1], 5);
`ifdef LSU_ACCESS_CNT_EN
      chk("load_cnt", 1, load_cnt[1], 32'd2);
      chk("store_cnt", 1, store_cnt[1], 32'd1);
      chk("err_cnt", 1, 32'(err_cnt[1]), 32'd0);
      chk("load_cnt", 0, load_cnt[0], 32'd5);
      chk("store_cnt", 0, store_cnt[0], 32'd3);
      chk("err_cnt", 0, 32'(err_cnt[0]), 32'd4);
`endif
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu_bram_master.md
Name: lsu_bram_master

Overview:
- Load/store initiator that sits between the CPU memory (M) stage and a single-port block RAM data memory: clock/enable, 4-bit byte write enables, word address, write data in, read data out.
- Accepts one byte, halfword or word access at a time.
- Generates byte-lane enables and replicated write data, waits out the RAM read latency, then returns aligned and extended load data.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- ADDR_W, 10, RAM word-address width; mem_addr = req_addr[ADDR_W+1:2].
- READ_LAT, 1, RAM read latency in cycles; legal range 1..3.

Ports:
- clk  in  1  clock; the RAM is clocked from the same net.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  sign-extend load result.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; access was rejected.
- resp_rdata  out  32  load result; 0 for stores and errors.
- mem_en  out  1  RAM enable.
- mem_we  out  4  RAM byte write enables; bit k writes din[8k+7:8k].
- mem_addr  out  ADDR_W  RAM word address.
- mem_din  out  32  RAM write data.
- mem_dout  in  32  RAM read data.

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs 0 except req_ready=1. Any in-flight access is dropped; mem_en and mem_we fall immediately.
- Handshake: a request is accepted when req_valid && req_ready. All request fields are registered at acceptance. resp_valid has no backpressure.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on accept, go to ISSUE, or to RESP if the request is erroneous.
- ISSUE: drives mem_en=1, mem_addr, and mem_we/mem_din from the registered request.
  - Store: go to RESP.
  - Load: mem_we=0; go to WAIT.
- WAIT: lasts READ_LAT cycles. In the last WAIT cycle, capture mem_dout into the aligner, then go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. req_ready returns the following cycle.
- Latency, accept at cycle T:
  - Store: mem_we at T+1, resp_valid at T+2.
  - Load: resp_valid at T+2+READ_LAT.
  - Error: resp_valid at T+1 with resp_err=1. mem_en never asserts.
- Error conditions:
  - req_size==3.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - req_addr[31:ADDR_W+2] != 0.
- Lanes (little-endian, lane k = addr[1:0]):
  - Byte: mem_we = 1<<addr[1:0].
  - Half: addr[1]=0 gives 4'b0011; addr[1]=1 gives 4'b1100.
  - Word: 4'b1111.
- Store data:
  - Byte: wdata[7:0] replicated x4.
  - Half: wdata[15:0] replicated x2.
  - Word: as-is.
- Load data: the selected lane(s) are shifted to bit 0. They are zero-extended, or sign-extended when req_signed=1. req_signed is ignored for word loads.
- No write-then-read forwarding is needed: only one access is outstanding, and the RAM write completes at ISSUE.

Optional Feature:
- Macro: LSU_ACCESS_CNT_EN.
- Defined: adds output ports load_cnt[31:0], store_cnt[31:0] and err_cnt[15:0].
  - Each counter increments in the RESP cycle of its access type; errors count only in err_cnt.
  - Counters wrap silently and reset to 0.
- Undefined: ports and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State encoding.
  - Function lane_mask(size, addr[1:0]).
  - Function misaligned(size, addr[1:0]).
- Sub-module lsu_load_align: combinational extract and extend from (word, addr[1:0], size, signed) to 32-bit result.

Test Plan:
1. Reset mid-load: assert rst=0 during WAIT.
   - Outputs zero immediately, req_ready=1 after release.
   - No resp_valid pulse is produced for the dropped load.
2. Word store then load, READ_LAT=1:
   - Store 0xDEADBEEF to 0x10: mem_we=4'b1111, mem_addr=4, mem_din=0xDEADBEEF at T+1; resp_valid at T+2.
   - Load from 0x10: resp_rdata=0xDEADBEEF at T'+3.
3. Byte store to 0x13 with wdata 0x000000A5:
   - mem_we=4'b1000, mem_din=0xA5A5A5A5.
   - Signed byte load from 0x13 returns 0xFFFFFFA5; unsigned returns 0x000000A5.
4. Half store 0x8001 to 0x22:
   - mem_we=4'b1100.
   - Signed half load from 0x22 returns 0xFFFF8001; unsigned returns 0x00008001.
5. Error cases, each checked individually:
   - Word load from 0x06, half store to 0x03, access with size=3, access to 0x00001000 (ADDR_W=10).
   - Each gives resp_valid with resp_err=1 at T+1, resp_rdata=0, and mem_en never high.
6. Back-to-back requests with req_valid held high:
   - req_valid is ignored while req_ready=0.
   - With READ_LAT=3, a load-store-load sequence completes in order with the correct per-request latencies.
   - With LSU_ACCESS_CNT_EN defined: load_cnt=2 and store_cnt=1 at the end.
